// File: rtl/elink_sched_pkg.sv
// Shared constants and state type for the e-link transmit scheduler.
// A character is {hdr[1:0], payload[7:0]}, shifted out MSB-first as five 2-bit symbols.
package elink_sched_pkg;

  localparam logic [1:0] HDR_IDLE = 2'b00;
  localparam logic [1:0] HDR_SOP  = 2'b01;
  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_EOP  = 2'b11;

  localparam logic [7:0] PL_IDLE  = 8'h00;
  localparam logic [7:0] PL_STALL = 8'h01;

  localparam int SYMS_PER_CHAR = 5;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN} state_t;

endpackage

// File: rtl/elink_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the slot after last_ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int CH_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [CH_W-1:0]  last_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [CH_W-1:0]  gnt_idx
);

  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = CH_W'((int'(last_ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/elink_tx_scheduler.sv
// Shares one 2-bit e-link between N_REQ byte-stream requesters, granting whole frames
// round-robin and framing them as SOP / DATA / STALL / EOP characters with IDLE fill.
module elink_tx_scheduler
  import elink_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CH_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [1:0]         tx_elink2bit,
  output logic               busy,
  output logic [CH_W-1:0]    grant_id,
  output logic               frame_done
);

  state_t            state, state_nxt;
  logic [2:0]        sym_cnt;
  logic [9:0]        shreg, char_nxt;
  logic [CH_W-1:0]   last_ptr;
  logic [N_REQ-1:0]  arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;
  logic              boundary;
  logic              take_grant;
  logic [7:0]        sel_byte;

  rr_arbiter #(.N_REQ(N_REQ), .CH_W(CH_W)) u_arb (
    .req      (req_valid),
    .last_ptr (last_ptr),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  assign arb_any      = |arb_gnt;
  assign boundary     = (sym_cnt == 3'(SYMS_PER_CHAR - 1));
  assign sel_byte     = req_data[{grant_id, 3'b000} +: 8];
  assign tx_elink2bit = shreg[9:8];
  assign busy         = (state != S_IDLE);
  assign frame_done   = boundary && (state == S_DRAIN);

  // DRAIN's boundary doubles as an IDLE decision so back-to-back frames need no gap.
  always_comb begin
    state_nxt  = state;
    char_nxt   = {HDR_IDLE, PL_IDLE};
    take_grant = 1'b0;
    req_ready  = '0;
    if (boundary) begin
      unique case (state)
        S_DATA: begin
          req_ready[grant_id] = 1'b1;
          if (req_valid[grant_id]) begin
            if (req_last[grant_id]) begin
              char_nxt  = {HDR_EOP, sel_byte};
              state_nxt = S_DRAIN;
            end else begin
              char_nxt  = {HDR_DATA, sel_byte};
            end
          end else begin
            char_nxt = {HDR_IDLE, PL_STALL};
          end
        end
        default: begin
          state_nxt = S_IDLE;
          if (enable && arb_any) begin
            char_nxt   = {HDR_SOP, 8'(arb_idx)};
            take_grant = 1'b1;
            state_nxt  = S_DATA;
          end
        end
      endcase
    end
  end

  // The pointer resets to N_REQ-1 so the first search starts at requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      sym_cnt  <= '0;
      shreg    <= '0;
      grant_id <= '0;
      last_ptr <= CH_W'(N_REQ - 1);
    end else begin
      state   <= state_nxt;
      sym_cnt <= boundary ? 3'd0 : sym_cnt + 3'd1;
      shreg   <= boundary ? char_nxt : {shreg[7:0], 2'b00};
      if (take_grant) begin
        grant_id <= arb_idx;
        last_ptr <= arb_idx;
      end
    end
  end

endmodule

// File: tb/tb_elink_tx_scheduler.sv
// Directed bench for elink_tx_scheduler with N_REQ=4; each character is checked symbol by
// symbol against hand-encoded values, along with frame_done, req_ready, busy and grant_id.
module tb_elink_tx_scheduler;

  localparam int N_REQ = 4;
  localparam int CH_W  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [1:0]         tx_elink2bit;
  logic               busy;
  logic [CH_W-1:0]    grant_id;
  logic               frame_done;

  int vectors    = 0;
  int miscompares = 0;
  int phase      = 0;

  always #5 clk = ~clk;

  elink_tx_scheduler #(.N_REQ(N_REQ), .CH_W(CH_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_elink2bit (tx_elink2bit),
    .busy         (busy),
    .grant_id     (grant_id),
    .frame_done   (frame_done)
  );

  task automatic check_output(input logic [31:0] observed, input logic [31:0] expected,
                              input string tag);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle: phase tracks the expected symbol counter, 4 being a load boundary.
  task automatic sym_check(input logic [1:0] exp_sym, input logic exp_done,
                           input logic [N_REQ-1:0] exp_rdy, input string tag);
    @(negedge clk);
    phase = (phase + 1) % 5;
    check_output(32'(tx_elink2bit), 32'(exp_sym), {tag, " sym"});
    check_output(32'(frame_done), 32'(exp_done), {tag, " frame_done"});
    check_output(32'(req_ready), 32'(exp_rdy), {tag, " req_ready"});
  endtask

  task automatic char_step(input logic [9:0] exp_char, input logic exp_done,
                           input logic [N_REQ-1:0] exp_rdy_end, input string tag);
    for (int i = 0; i < 5; i++)
      sym_check(exp_char[9-2*i -: 2], (i == 4) && exp_done,
                (i == 4) ? exp_rdy_end : '0, tag);
  endtask

  task automatic align_boundary(input string tag);
    while (phase != 4) sym_check(2'b00, 1'b0, '0, tag);
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    check_output(32'(tx_elink2bit), 32'd0, "rst tx");
    check_output(32'(busy), 32'd0, "rst busy");
    check_output(32'(req_ready), 32'd0, "rst ready");
    check_output(32'(grant_id), 32'd0, "rst grant");
    check_output(32'(frame_done), 32'd0, "rst done");

    // Quiet link after reset: zero symbols, never busy.
    reset = 1'b1;
    phase = 0;
    for (int c = 0; c < 50; c++) begin
      sym_check(2'b00, 1'b0, '0, "quiet");
      check_output(32'(busy), 32'd0, "quiet busy");
    end
    align_boundary("quiet align");

    // Requester 2: A5 then 3C (last).
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    char_step(10'b01_0000_0010, 1'b0, 4'b0100, "r2 sop");
    check_output(32'(grant_id), 32'd2, "r2 grant");
    check_output(32'(busy), 32'd1, "r2 busy");
    char_step(10'b10_1010_0101, 1'b0, 4'b0100, "r2 data");
    req_data[23:16] = 8'h3C;
    req_last = 4'b0100;
    char_step(10'b11_0011_1100, 1'b1, 4'b0000, "r2 eop");
    req_valid = '0;
    req_last  = '0;
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "r2 idle");
    check_output(32'(busy), 32'd0, "r2 busy end");

    // Requester 1 with a 7-cycle valid gap mid-frame.
    req_valid = 4'b0010;
    req_data[15:8] = 8'h5A;
    char_step(10'b01_0000_0001, 1'b0, 4'b0010, "r1 sop");
    check_output(32'(grant_id), 32'd1, "r1 grant");
    char_step(10'b10_0101_1010, 1'b0, 4'b0010, "r1 data");
    req_valid = '0;
    char_step(10'b00_0000_0001, 1'b0, 4'b0010, "r1 stall");
    sym_check(2'b00, 1'b0, '0, "r1 stall2");
    sym_check(2'b00, 1'b0, '0, "r1 stall2");
    req_valid = 4'b0010;
    req_data[15:8] = 8'hC3;
    req_last = 4'b0010;
    sym_check(2'b00, 1'b0, '0, "r1 stall2");
    sym_check(2'b00, 1'b0, '0, "r1 stall2");
    sym_check(2'b01, 1'b0, 4'b0010, "r1 stall2");
    char_step(10'b11_1100_0011, 1'b1, 4'b0000, "r1 eop");
    req_valid = '0;
    req_last  = '0;
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "r1 idle");

    // Reset in the middle of a DATA character from requester 2.
    req_valid = 4'b0100;
    req_data[23:16] = 8'h77;
    char_step(10'b01_0000_0010, 1'b0, 4'b0100, "mid sop");
    check_output(32'(grant_id), 32'd2, "mid grant");
    sym_check(2'b10, 1'b0, '0, "mid data");
    sym_check(2'b01, 1'b0, '0, "mid data");
    sym_check(2'b11, 1'b0, '0, "mid data");
    reset     = 1'b0;
    req_valid = '0;
    #1;
    check_output(32'(tx_elink2bit), 32'd0, "mid rst tx");
    check_output(32'(busy), 32'd0, "mid rst busy");
    check_output(32'(req_ready), 32'd0, "mid rst ready");
    check_output(32'(grant_id), 32'd0, "mid rst grant");
    repeat (2) @(negedge clk);
    check_output(32'(tx_elink2bit), 32'd0, "mid rst hold");
    reset = 1'b1;
    phase = 0;
    align_boundary("post rst align");
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "post rst idle");

    // Requesters 0, 1, 3 with one-byte frames, back to back.
    req_valid = 4'b1011;
    req_last  = 4'b1011;
    req_data  = 32'h33_00_22_11;
    char_step(10'b01_0000_0000, 1'b0, 4'b0001, "rr sop0");
    check_output(32'(grant_id), 32'd0, "rr grant0");
    char_step(10'b11_0001_0001, 1'b1, 4'b0000, "rr eop0");
    check_output(32'(busy), 32'd1, "rr busy0");
    char_step(10'b01_0000_0001, 1'b0, 4'b0010, "rr sop1");
    check_output(32'(grant_id), 32'd1, "rr grant1");
    char_step(10'b11_0010_0010, 1'b1, 4'b0000, "rr eop1");
    char_step(10'b01_0000_0011, 1'b0, 4'b1000, "rr sop3");
    check_output(32'(grant_id), 32'd3, "rr grant3");
    char_step(10'b11_0011_0011, 1'b1, 4'b0000, "rr eop3");
    char_step(10'b01_0000_0000, 1'b0, 4'b0001, "rr sop0b");
    check_output(32'(grant_id), 32'd0, "rr grant0b");
    char_step(10'b11_0001_0001, 1'b1, 4'b0000, "rr eop0b");

    // enable low blocks new grants but lets a running frame finish.
    enable    = 1'b0;
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "en idle");
    check_output(32'(busy), 32'd0, "en busy");
    req_valid = 4'b0010;
    req_last  = '0;
    req_data[15:8] = 8'h22;
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "en idle r1");
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "en idle r1");
    enable = 1'b1;
    char_step(10'b01_0000_0001, 1'b0, 4'b0010, "en sop1");
    enable = 1'b0;
    char_step(10'b10_0010_0010, 1'b0, 4'b0010, "en data");
    req_data[15:8] = 8'h9E;
    req_last = 4'b0010;
    char_step(10'b11_1001_1110, 1'b1, 4'b0000, "en eop");
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "en after");
    char_step(10'b00_0000_0000, 1'b0, 4'b0000, "en after");
    check_output(32'(grant_id), 32'd1, "en grant");
    check_output(32'(busy), 32'd0, "en busy end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
